seg_frame_capture: RTL and testbench

Passive monitor at the pin side of the four-digit multiplexed seven-segment display. It samples the active-low digit-select and segment lines and decodes each stable segment pattern back to a hex nibble. Once all four digits have been captured, it reassembles the 16-bit word that the display driver was given. It is used in board-level self-checks and benches to read back what the display is actually showing.

---
 rtl/seg_frame_capture.sv | 168 ++++++++++++++++
 tb/tb_seg_frame_capture.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_capture.sv
// seg_frame_capture
//   Passive monitor for a four-digit multiplexed seven-segment display.
//   It samples the active-low digit-select and segment pins and waits for
//   each pin pattern to settle. Each settled segment pattern is decoded
//   back to a hex nibble. When all four digits have been seen, it
//   rebuilds the 16-bit word the display driver was showing.
//
// Parameters
//   STABLE_CYCLES  cycles a synchronised pin value must hold before it is
//                  captured (1..255)
//
// Ports
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   pos_ctrl    [3:0] digit select, active-low (bit 3 = most significant digit)
//   num_ctrl    [7:0] segments, active-low, {dp,g,f,e,d,c,b,a}; dp is ignored
//   data_out    [15:0] last completely captured word
//   data_valid  one-cycle pulse when data_out is updated
//   seg_err     one-cycle pulse when an undecodable pattern is captured
//   pos_err     one-cycle pulse when a captured select has several bits low
module seg_frame_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  pos_ctrl,
    input  logic [7:0]  num_ctrl,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        seg_err,
    output logic        pos_err
);

    localparam logic [7:0] STAB_TGT = 8'(STABLE_CYCLES);

    // Returns {known, nibble} for an active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    logic [11:0] meta_p0;
    logic [11:0] sync_p1;
    logic [11:0] prev_p2;
    logic [7:0]  stab_p2;
    logic [7:0]  stab_nxt;
    logic        changed;
    logic        capture;
    logic        vld_p3;
    logic [10:0] cap_p3;     // {pos_ctrl, segments} of the captured value
    logic [3:0]  seen;
    logic [15:0] digits;

    // ---- stage p0/p1: two-flop synchroniser, blank (all ones) at reset ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            meta_p0 <= {pos_ctrl, num_ctrl};
            sync_p1 <= meta_p0;
        end
    end

    // The dp bit takes part in the stability comparison even though its
    // value is discarded: any pin movement restarts the settle window.
    always_comb begin
        changed  = (sync_p1 != prev_p2);
        stab_nxt = changed ? 8'd1
                 : ((stab_p2 == 8'hFF) ? stab_p2 : stab_p2 + 8'd1);
        // A new stable period may reach the target on its first cycle
        // (STABLE_CYCLES = 1) while stab_p2 already equals the target.
        capture  = (stab_nxt == STAB_TGT) && (changed || (stab_p2 != STAB_TGT));
    end

    // ---- stage p2/p3: stability counter and capture register ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev_p2 <= '1;
            stab_p2 <= '0;
            vld_p3  <= 1'b0;
            cap_p3  <= '1;
        end else begin
            prev_p2 <= sync_p1;
            stab_p2 <= stab_nxt;
            vld_p3  <= capture;
            cap_p3  <= {sync_p1[11:8], sync_p1[6:0]};
        end
    end

    logic [3:0]  sel;
    logic        blank;
    logic        multi;
    logic [1:0]  idx;
    logic [4:0]  dec;
    logic [3:0]  seen_set;
    logic [15:0] frame_word;

    always_comb begin
        sel   = ~cap_p3[10:7];
        blank = (sel == 4'b0000);
        multi = ((sel & (sel - 4'd1)) != 4'b0000);
        case (sel)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        dec        = seg_decode(cap_p3[6:0]);
        seen_set   = seen | (4'b0001 << idx);
        // Completed word includes the nibble captured this cycle.
        frame_word = digits;
        frame_word[{idx, 2'b00} +: 4] = dec[3:0];
    end

    // ---- stage p4: classification, frame assembly and output pulses ----
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seen       <= '0;
            digits     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            seg_err    <= 1'b0;
            pos_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            seg_err    <= 1'b0;
            pos_err    <= 1'b0;
            if (vld_p3 && !blank) begin
                if (multi) begin
                    pos_err <= 1'b1;
                end else if (dec[4]) begin
                    digits <= frame_word;
                    if (seen_set == 4'b1111) begin
                        data_out   <= frame_word;
                        data_valid <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_set;
                    end
                end else begin
                    // A garbled digit must be seen cleanly again before
                    // the frame can complete.
                    seg_err   <= 1'b1;
                    seen[idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_frame_capture.sv
module tb_seg_frame_capture;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  pos_ctrl;
    logic [7:0]  num_ctrl;
    logic [15:0] data_out;
    logic        data_valid;
    logic        seg_err;
    logic        pos_err;

    seg_frame_capture #(.STABLE_CYCLES(N)) dut (
        .clk        (clk),
        .clr        (clr),
        .pos_ctrl   (pos_ctrl),
        .num_ctrl   (num_ctrl),
        .data_out   (data_out),
        .data_valid (data_valid),
        .seg_err    (seg_err),
        .pos_err    (pos_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled 1 time unit after each rising edge.
    int          dv_cnt = 0;
    int          se_cnt = 0;
    int          pe_cnt = 0;
    int          excl_viol = 0;
    logic [15:0] obs_q[$];

    always @(posedge clk) begin
        #1;
        if (data_valid) begin
            dv_cnt++;
            obs_q.push_back(data_out);
        end
        if (seg_err) se_cnt++;
        if (pos_err) pe_cnt++;
        if (int'(data_valid) + int'(seg_err) + int'(pos_err) > 1) excl_viol++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after cyc cycles.
    task automatic hold(input logic [3:0] p, input logic [7:0] n, input int cyc);
        pos_ctrl = p;
        num_ctrl = n;
        repeat (cyc) @(negedge clk);
    endtask

    logic [6:0] seg_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic int pat_index(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (seg_pat[k] == s) return k;
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  pos;
        logic [7:0]  num;
        int          hold;
        int          dv;
        int          se;
        int          pe;
        logic [15:0] dat;
    } vec_t;

    typedef struct {
        logic [11:0] v;
        int          len;
    } run_t;

    vec_t tbl[$];
    run_t runs[$];
    logic [15:0] exp_q[$];

    initial begin
        int dv0, se0, pe0, lat;
        clr      = 1'b1;
        pos_ctrl = 4'hF;
        num_ctrl = 8'hFF;

        // Directed vectors; pulses are counted over each row's window.
        // frame 1a9b with a short glitch between two digits
        tbl.push_back('{4'b0111, 8'h79, 10, 0, 0, 0, 16'h0000});
        tbl.push_back('{4'b1011, 8'h08, 10, 0, 0, 0, 16'h0000});
        tbl.push_back('{4'b1101, 8'hFF,  2, 0, 0, 0, 16'h0000});
        tbl.push_back('{4'b1101, 8'h10, 10, 0, 0, 0, 16'h0000});
        tbl.push_back('{4'b1110, 8'h03, 10, 1, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1111, 8'hFF,  8, 0, 0, 0, 16'h1a9b});
        // several selects low together
        tbl.push_back('{4'b1100, 8'hFF, 10, 0, 0, 1, 16'h1a9b});
        // invalid digit 2 withholds the frame until it is seen again
        tbl.push_back('{4'b0111, 8'h79, 10, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1011, 8'h7F, 10, 0, 1, 0, 16'h1a9b});
        tbl.push_back('{4'b1101, 8'h10, 10, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1110, 8'h03, 10, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1011, 8'h08, 10, 1, 0, 0, 16'h1a9b});
        // frame 45CF: digit 3 held exactly N cycles, an N-1 cycle invalid glitch
        tbl.push_back('{4'b0111, 8'h19,  4, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1011, 8'h12,  8, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1110, 8'h7F,  3, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1101, 8'h46,  8, 0, 0, 0, 16'h1a9b});
        tbl.push_back('{4'b1110, 8'h0E,  8, 1, 0, 0, 16'h45CF});
        // frame 0236
        tbl.push_back('{4'b0111, 8'h40,  8, 0, 0, 0, 16'h45CF});
        tbl.push_back('{4'b1011, 8'h24,  8, 0, 0, 0, 16'h45CF});
        tbl.push_back('{4'b1101, 8'h30,  8, 0, 0, 0, 16'h45CF});
        tbl.push_back('{4'b1110, 8'h02,  8, 1, 0, 0, 16'h0236});
        // frame 78dE, digit 3 overwritten before completion
        tbl.push_back('{4'b0111, 8'h40,  8, 0, 0, 0, 16'h0236});
        tbl.push_back('{4'b0111, 8'h78,  8, 0, 0, 0, 16'h0236});
        tbl.push_back('{4'b1011, 8'h00,  8, 0, 0, 0, 16'h0236});
        tbl.push_back('{4'b1101, 8'h21,  8, 0, 0, 0, 16'h0236});
        tbl.push_back('{4'b1110, 8'h06,  8, 1, 0, 0, 16'h78dE});

        // Reset state, held while clr is high
        repeat (3) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_seg_err", 32'(seg_err), 32'h0);
        chk("rst_pos_err", 32'(pos_err), 32'h0);
        clr = 1'b0;
        hold(4'hF, 8'hFF, 10);

        for (int i = 0; i < tbl.size(); i++) begin
            dv0 = dv_cnt; se0 = se_cnt; pe0 = pe_cnt;
            hold(tbl[i].pos, tbl[i].num, tbl[i].hold);
            chk($sformatf("row%0d_dv", i), 32'(dv_cnt - dv0), 32'(tbl[i].dv));
            chk($sformatf("row%0d_se", i), 32'(se_cnt - se0), 32'(tbl[i].se));
            chk($sformatf("row%0d_pe", i), 32'(pe_cnt - pe0), 32'(tbl[i].pe));
            chk($sformatf("row%0d_data", i), 32'(data_out), 32'(tbl[i].dat));
        end

        // Latency: the completing digit is applied before edge 0
        hold(4'b0111, 8'h12, 8);
        hold(4'b1011, 8'h08, 8);
        hold(4'b1101, 8'h78, 8);
        pos_ctrl = 4'b1110;
        num_ctrl = 8'h30;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (data_valid && lat < 0) lat = k;
        end
        @(negedge clk);
        chk("latency_edge", 32'(lat), 32'(N + 2));
        chk("latency_data", 32'(data_out), 32'h5A73);

        // Reset mid-frame: digits 3 and 2 of F00D, then a 1-cycle clr
        hold(4'hF, 8'hFF, 4);
        hold(4'b0111, 8'h0E, 8);
        hold(4'b1011, 8'h40, 8);
        hold(4'hF, 8'hFF, 4);
        clr = 1'b1;
        #1;
        chk("clr_async_data", 32'(data_out), 32'h0);
        chk("clr_async_dv", 32'(data_valid), 32'h0);
        chk("clr_async_se", 32'(seg_err), 32'h0);
        chk("clr_async_pe", 32'(pos_err), 32'h0);
        @(negedge clk);
        clr = 1'b0;
        dv0 = dv_cnt; se0 = se_cnt;
        // low digits first: any surviving partial frame would complete early
        hold(4'b1101, 8'h30, 8);
        hold(4'b1110, 8'h19, 8);
        hold(4'b0111, 8'h79, 8);
        chk("clr_no_mix_dv", 32'(dv_cnt - dv0), 32'h0);
        // completing digit held long: exactly one frame, no repeat capture
        hold(4'b1011, 8'h24, 300);
        chk("clr_frame_dv", 32'(dv_cnt - dv0), 32'h1);
        chk("clr_frame_data", 32'(data_out), 32'h1234);
        chk("clr_frame_se", 32'(se_cnt - se0), 32'h0);

        // Long hold of an undecodable digit: one seg_err despite saturation
        dv0 = dv_cnt; se0 = se_cnt;
        hold(4'b1110, 8'h7F, 600);
        chk("hold_invalid_se", 32'(se_cnt - se0), 32'h1);
        chk("hold_invalid_dv", 32'(dv_cnt - dv0), 32'h0);
        chk("hold_invalid_data", 32'(data_out), 32'h1234);

        // Randomised runs against a run-length reference model
        begin
            logic [11:0] v;
            logic [3:0]  p;
            logic [6:0]  s;
            int          len, kind, zeros, pidx, didx;
            int          exp_se, exp_pe;
            logic [3:0]  m_dig [4];
            logic [3:0]  m_seen;
            logic [15:0] last_word;

            hold(4'hF, 8'hFF, 10);
            runs.delete();
            runs.push_back('{12'hFFF, 10});
            obs_q.delete();
            se0 = se_cnt; pe0 = pe_cnt;

            for (int r = 0; r < 250; r++) begin
                kind = int'($urandom_range(0, 9));
                if (kind == 0) begin
                    p = 4'hF;
                    s = 7'($urandom);
                end else if (kind == 1) begin
                    do p = 4'($urandom); while ($countones(~p) < 2);
                    s = 7'($urandom);
                end else begin
                    p = ~(4'b0001 << $urandom_range(0, 3));
                    if (kind == 2) begin
                        do s = 7'($urandom); while (pat_index(s) >= 0);
                    end else begin
                        s = seg_pat[$urandom_range(0, 15)];
                    end
                end
                v   = {p, 1'($urandom), s};
                len = int'($urandom_range(1, 9));
                hold(v[11:8], v[7:0], len);
                if (runs[runs.size() - 1].v == v) runs[runs.size() - 1].len += len;
                else runs.push_back('{v, len});
            end
            hold(4'hF, 8'hFF, 20);
            if (runs[runs.size() - 1].v == 12'hFFF) runs[runs.size() - 1].len += 20;
            else runs.push_back('{12'hFFF, 20});

            // Every merged run of at least N cycles is one capture
            exp_q.delete();
            exp_se = 0; exp_pe = 0;
            m_seen = 4'b0000;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
            for (int r = 0; r < runs.size(); r++) begin
                if (runs[r].len < N) continue;
                p = runs[r].v[11:8];
                zeros = $countones(~p);
                if (zeros == 0) continue;
                if (zeros >= 2) begin
                    exp_pe++;
                    continue;
                end
                didx = 0;
                for (int k = 0; k < 4; k++) if (!p[k]) didx = k;
                pidx = pat_index(runs[r].v[6:0]);
                if (pidx < 0) begin
                    exp_se++;
                    m_seen[didx] = 1'b0;
                end else begin
                    m_dig[didx] = 4'(pidx);
                    m_seen[didx] = 1'b1;
                    if (m_seen == 4'b1111) begin
                        exp_q.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
                        m_seen = 4'b0000;
                    end
                end
            end

            chk("rand_frames", 32'(obs_q.size()), 32'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
                chk($sformatf("rand_word%0d", k), 32'(obs_q[k]), 32'(exp_q[k]));
            chk("rand_seg_err", 32'(se_cnt - se0), 32'(exp_se));
            chk("rand_pos_err", 32'(pe_cnt - pe0), 32'(exp_pe));
            last_word = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : 16'h1234;
            chk("rand_final_data", 32'(data_out), 32'(last_word));
        end

        chk("pulse_exclusive", 32'(excl_viol), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
